histo_equalize_ctrl: RTL and testbench

Sequences the histogram-equalization stage of the video pipeline. Consumes the 256-bin histogram burst produced at the end of each frame and accumulates it into a cumulative distribution. Converts the CDF into an 8-bit remap LUT held in a ping-pong pair of banks. Swaps banks at the next frame start and remaps the live pixel stream through the active bank.

---
 rtl/histo_equalize_ctrl.sv | 174 +++++++++++++++++
 tb/tb_histo_equalize_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_equalize_ctrl.sv
// Histogram-equalization sequencer: accumulates a 256-bin histogram burst into a CDF and builds an 8-bit remap LUT.
// LUT entry written 2 cycles after its bin; bank swap on the first vsync edge once the table is complete; remap 1 cycle.
// No backpressure: the remap path never stalls; malformed or rejected bursts are flagged on po_frame_err and dropped.
module histo_equalize_ctrl #(
  parameter int IMG_WIDTH   = 480,
  parameter int IMG_HEIGHT  = 272,
  parameter int GRAY_LEVEL  = 256,
  parameter int SCALE_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pi_vsync,
  input  logic        pi_histo_vld,
  input  logic [63:0] pi_histo_data,
  input  logic        pi_data_vld,
  input  logic [7:0]  pi_data,
  output logic        po_data_vld,
  output logic [7:0]  po_data,
  output logic        po_lut_ready,
  output logic        po_frame_err
);

  // 255 * 2^SCALE_SHIFT / pixel count; 32768 at 480x272 with a 24-bit shift
  localparam logic [63:0] SCALE = (64'd255 << SCALE_SHIFT) / (64'(IMG_WIDTH) * 64'(IMG_HEIGHT));

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, PENDING} state_t;

  state_t      state_q;
  logic [1:0]  vsync_dd_q;
  logic        vsync_edge;
  logic [63:0] cdf_q;
  logic [7:0]  bin_cnt_q;
  logic        flush_cnt_q;
  logic        rej_q;
  logic        act_bank_q;
  logic        lut_ready_q;
  logic        frame_err_q;

  // stage 1 is the CDF register itself plus the bin index that produced it
  logic        s1_vld_q;
  logic [7:0]  s1_idx_q;
  logic        s2_vld_q;
  logic [7:0]  s2_idx_q;
  logic [63:0] prod_q;
  logic        s2_sat_q;
  logic [63:0] prod_d;
  logic [63:0] scaled;
  logic [7:0]  lut_d;

  logic [7:0]  bank0_q [GRAY_LEVEL];
  logic [7:0]  bank1_q [GRAY_LEVEL];
  logic [7:0]  data_q;
  logic        data_vld_q;

  assign vsync_edge = (vsync_dd_q == 2'b01);

  // vsync history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) vsync_dd_q <= 2'b00;
    else     vsync_dd_q <= {vsync_dd_q[0], pi_vsync};
  end

  // burst sequencer: accumulate, drain the scale pipe, then wait for a frame start to commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cdf_q       <= 64'd0;
      bin_cnt_q   <= 8'd0;
      flush_cnt_q <= 1'b0;
      rej_q       <= 1'b0;
      act_bank_q  <= 1'b0;
      lut_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= 8'd0;
    end else begin
      frame_err_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      // a rejected burst is ignored until its valid drops, so its tail is never taken as a new burst
      if (!pi_histo_vld) rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pi_histo_vld && !rej_q) begin
            cdf_q     <= pi_histo_data;
            bin_cnt_q <= 8'd1;
            s1_vld_q  <= 1'b1;
            s1_idx_q  <= 8'd0;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          if (pi_histo_vld) begin
            cdf_q     <= cdf_q + pi_histo_data;
            bin_cnt_q <= bin_cnt_q + 8'd1;
            s1_vld_q  <= 1'b1;
            s1_idx_q  <= bin_cnt_q;
            if (bin_cnt_q == 8'd255) begin
              flush_cnt_q <= 1'b0;
              state_q     <= FLUSH;
            end
          end else begin
            // short burst: the inactive bank keeps whatever was written, nothing is committed
            frame_err_q <= 1'b1;
            cdf_q       <= 64'd0;
            bin_cnt_q   <= 8'd0;
            state_q     <= IDLE;
          end
        end
        FLUSH: begin
          flush_cnt_q <= 1'b1;
          if (flush_cnt_q) state_q <= PENDING;
        end
        PENDING: begin
          if (vsync_edge) begin
            act_bank_q  <= ~act_bank_q;
            lut_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
          if (pi_histo_vld && !rej_q) begin
            frame_err_q <= 1'b1;
            rej_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prod_d = {32'd0, cdf_q[31:0]} * SCALE;
  assign scaled = prod_q >> SCALE_SHIFT;
  // any CDF bits above 32 mean the product is meaningless, so clamp like any other overflow
  assign lut_d  = (s2_sat_q || (scaled > 64'd255)) ? 8'hFF : scaled[7:0];

  // stage 2: scale the CDF and carry the overflow flag alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_idx_q <= 8'd0;
      prod_q   <= 64'd0;
      s2_sat_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_idx_q <= s1_idx_q;
      prod_q   <= prod_d;
      s2_sat_q <= |cdf_q[63:32];
    end
  end

  // LUT write into the bank not currently used by the pixel stream
  always_ff @(posedge clk) begin
    if (s2_vld_q) begin
      if (act_bank_q) bank0_q[s2_idx_q] <= lut_d;
      else            bank1_q[s2_idx_q] <= lut_d;
    end
  end

  // pixel remap through the active bank, identity until a table has been committed
  always_ff @(posedge clk) begin
    if (rst) begin
      data_vld_q <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      data_vld_q <= pi_data_vld;
      if (lut_ready_q) data_q <= act_bank_q ? bank1_q[pi_data] : bank0_q[pi_data];
      else             data_q <= pi_data;
    end
  end

  assign po_data_vld  = data_vld_q;
  assign po_data      = data_q;
  assign po_lut_ready = lut_ready_q;
  assign po_frame_err = frame_err_q;

endmodule

// File: tb/tb_histo_equalize_ctrl.sv
// Self-checking bench for histo_equalize_ctrl: reference LUT built from the histogram by cumulative sums.
// Pixel remap checked through the DUT's 1-cycle stream; bursts and vsync driven as whole-frame events.
// Randomized histograms and pixel streams alongside the fixed test-plan cases.
`timescale 1ns/1ps
module tb_histo_equalize_ctrl;

  localparam longint unsigned SCALE_REF = (64'd255 << 24) / (64'd480 * 64'd272);

  logic        clk = 1'b0;
  logic        rst;
  logic        pi_vsync;
  logic        pi_histo_vld;
  logic [63:0] pi_histo_data;
  logic        pi_data_vld;
  logic [7:0]  pi_data;
  logic        po_data_vld;
  logic [7:0]  po_data;
  logic        po_lut_ready;
  logic        po_frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] hist      [256];
  logic [7:0]  pend_lut  [256];
  logic [7:0]  model_lut [256];
  bit          model_ready;

  always #5 clk = ~clk;

  histo_equalize_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pi_vsync      (pi_vsync),
    .pi_histo_vld  (pi_histo_vld),
    .pi_histo_data (pi_histo_data),
    .pi_data_vld   (pi_data_vld),
    .pi_data       (pi_data),
    .po_data_vld   (po_data_vld),
    .po_data       (po_data),
    .po_lut_ready  (po_lut_ready),
    .po_frame_err  (po_frame_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 2 ms");
    $fatal(1, "watchdog");
  end

  // reference: table = clamp(cumulative count * scale >> 24), saturating once the sum reaches 2^32
  task automatic build_model();
    logic [63:0] cum;
    logic [63:0] v;
    cum = 64'd0;
    for (int k = 0; k < 256; k++) begin
      cum = cum + hist[k];
      if (cum >= 64'h1_0000_0000) pend_lut[k] = 8'd255;
      else begin
        v = (cum * SCALE_REF) >> 24;
        pend_lut[k] = (v > 64'd255) ? 8'd255 : v[7:0];
      end
    end
  endtask

  function automatic logic [7:0] exp_map(input logic [7:0] p);
    return model_ready ? model_lut[p] : p;
  endfunction

  task automatic commit_model();
    for (int k = 0; k < 256; k++) model_lut[k] = pend_lut[k];
    model_ready = 1'b1;
  endtask

  task automatic send_burst(input int nbins);
    for (int i = 0; i < nbins; i++) begin
      @(posedge clk); #1;
      pi_histo_vld  = 1'b1;
      pi_histo_data = hist[i];
    end
    @(posedge clk); #1;
    pi_histo_vld  = 1'b0;
    pi_histo_data = 64'd0;
  endtask

  task automatic do_vsync();
    @(posedge clk); #1 pi_vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 pi_vsync = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic get_pix(input logic [7:0] p, output logic [7:0] o, output logic v);
    @(posedge clk); #1;
    pi_data     = p;
    pi_data_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o = po_data;
    v = po_data_vld;
    pi_data_vld = 1'b0;
  endtask

  task automatic count_err(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (po_frame_err) cnt++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] o;
    logic       v;
    rst = 1'b1; pi_vsync = 1'b0; pi_histo_vld = 1'b0; pi_histo_data = 64'd0;
    pi_data_vld = 1'b1; pi_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (po_data !== 8'd0)      begin n_bad++; $display("FAIL reset_po_data: got %0d expected 0", po_data); end
    n_cmp++; if (po_data_vld !== 1'b0)  begin n_bad++; $display("FAIL reset_po_data_vld: got %b expected 0", po_data_vld); end
    n_cmp++; if (po_lut_ready !== 1'b0) begin n_bad++; $display("FAIL reset_lut_ready: got %b expected 0", po_lut_ready); end
    n_cmp++; if (po_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", po_frame_err); end
    rst = 1'b0; pi_data_vld = 1'b0;
    model_ready = 1'b0;
    get_pix(8'h5A, o, v);
    n_cmp++; if (o !== 8'h5A) begin n_bad++; $display("FAIL reset_identity: got %0d expected 90", o); end
    n_cmp++; if (v !== 1'b1)  begin n_bad++; $display("FAIL reset_out_vld: got %b expected 1", v); end
  endtask

  task automatic test_truncated();
    int c;
    logic [7:0] o;
    logic       v;
    for (int k = 0; k < 256; k++) hist[k] = 64'd510;
    fork
      send_burst(100);
      count_err(110, c);
    join
    n_cmp++; if (c != 1) begin n_bad++; $display("FAIL trunc_err_pulses: got %0d expected 1", c); end
    do_vsync();
    n_cmp++; if (po_lut_ready !== 1'b0) begin n_bad++; $display("FAIL trunc_lut_ready: got %b expected 0", po_lut_ready); end
    get_pix(8'd37, o, v);
    n_cmp++; if (o !== 8'd37) begin n_bad++; $display("FAIL trunc_pix37: got %0d expected 37", o); end
  endtask

  task automatic test_uniform();
    logic [7:0] o;
    logic       v;
    logic       r1, r2;
    logic [7:0] pts [4];
    for (int k = 0; k < 256; k++) hist[k] = 64'd510;
    build_model();
    send_burst(256);
    repeat (6) @(posedge clk);
    // readiness appears at the edge where the swap registers
    @(posedge clk); #1 pi_vsync = 1'b1;
    @(posedge clk); @(negedge clk); r1 = po_lut_ready;
    @(posedge clk); @(negedge clk); r2 = po_lut_ready;
    #1 pi_vsync = 1'b0;
    commit_model();
    n_cmp++; if (r1 !== 1'b0) begin n_bad++; $display("FAIL uni_ready_early: got %b expected 0", r1); end
    n_cmp++; if (r2 !== 1'b1) begin n_bad++; $display("FAIL uni_ready_swap: got %b expected 1", r2); end
    pts[0] = 8'd0; pts[1] = 8'd1; pts[2] = 8'd127; pts[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      get_pix(pts[i], o, v);
      n_cmp++; if (o !== pts[i]) begin n_bad++; $display("FAIL uni_point: pixel %0d got %0d expected %0d", pts[i], o, pts[i]); end
    end
    for (int p = 0; p < 256; p++) begin
      get_pix(8'(p), o, v);
      n_cmp++; if (o !== exp_map(8'(p))) begin n_bad++; $display("FAIL uni_lut: pixel %0d got %0d expected %0d", p, o, exp_map(8'(p))); end
    end
  endtask

  task automatic test_ping_pong();
    logic [7:0] o, o1, o2, o3;
    logic       v;
    int         c;
    for (int k = 0; k < 256; k++) hist[k] = (k == 100) ? 64'd130560 : 64'd0;
    build_model();
    send_burst(256);
    repeat (6) @(posedge clk);
    get_pix(8'd50, o, v);
    n_cmp++; if (o !== 8'd50) begin n_bad++; $display("FAIL pp_old_bank: got %0d expected 50", o); end
    // a second burst while a table is pending must be refused and must not disturb that table
    for (int k = 0; k < 256; k++) hist[k] = 64'($urandom_range(0, 4000));
    fork
      send_burst(256);
      count_err(270, c);
    join
    n_cmp++; if (c != 1) begin n_bad++; $display("FAIL pp_reject_err: got %0d pulses expected 1", c); end
    @(posedge clk); #1;
    pi_vsync = 1'b1; pi_data = 8'd50; pi_data_vld = 1'b1;
    @(posedge clk); @(negedge clk); o1 = po_data;
    @(posedge clk); @(negedge clk); o2 = po_data;
    @(posedge clk); @(negedge clk); o3 = po_data;
    pi_vsync = 1'b0; pi_data_vld = 1'b0;
    n_cmp++; if (o1 !== 8'd50) begin n_bad++; $display("FAIL pp_swap_t1: got %0d expected 50", o1); end
    n_cmp++; if (o2 !== 8'd50) begin n_bad++; $display("FAIL pp_swap_t2: got %0d expected 50", o2); end
    n_cmp++; if (o3 !== 8'd0)  begin n_bad++; $display("FAIL pp_swap_t3: got %0d expected 0", o3); end
    commit_model();
    get_pix(8'd99, o, v);
    n_cmp++; if (o !== 8'd0)   begin n_bad++; $display("FAIL single_99: got %0d expected 0", o); end
    get_pix(8'd100, o, v);
    n_cmp++; if (o !== 8'd255) begin n_bad++; $display("FAIL single_100: got %0d expected 255", o); end
    for (int p = 0; p < 256; p++) begin
      get_pix(8'(p), o, v);
      n_cmp++; if (o !== exp_map(8'(p))) begin n_bad++; $display("FAIL single_lut: pixel %0d got %0d expected %0d", p, o, exp_map(8'(p))); end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] o;
    logic       v;
    for (int k = 0; k < 256; k++) hist[k] = 64'd0;
    hist[0] = 64'h2_0000_0000;
    build_model();
    send_burst(256);
    repeat (6) @(posedge clk);
    do_vsync();
    commit_model();
    for (int p = 0; p < 256; p++) begin
      get_pix(8'(p), o, v);
      n_cmp++; if (o !== 8'd255) begin n_bad++; $display("FAIL sat_lut: pixel %0d got %0d expected 255", p, o); end
    end
  endtask

  task automatic test_random();
    logic [7:0] o;
    logic       v;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 256; k++)
        hist[k] = (r == 2) ? 64'($urandom_range(0, 33554432)) : 64'($urandom_range(0, 1000));
      build_model();
      send_burst(256);
      repeat (6) @(posedge clk);
      do_vsync();
      commit_model();
      for (int p = 0; p < 256; p++) begin
        get_pix(8'(p), o, v);
        n_cmp++; if (o !== exp_map(8'(p))) begin n_bad++; $display("FAIL rand_lut: round %0d pixel %0d got %0d expected %0d", r, p, o, exp_map(8'(p))); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p, prev;
    prev = 8'd0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      p = 8'($urandom);
      pi_data = p; pi_data_vld = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (po_data_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_vld: cycle %0d got %b expected 1", i, po_data_vld); end
        n_cmp++; if (po_data !== exp_map(prev)) begin n_bad++; $display("FAIL b2b_data: cycle %0d got %0d expected %0d", i, po_data, exp_map(prev)); end
      end
      prev = p;
    end
    @(posedge clk); #1 pi_data_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if (po_data !== exp_map(prev)) begin n_bad++; $display("FAIL b2b_last: got %0d expected %0d", po_data, exp_map(prev)); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (po_data_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_vld_drop: got %b expected 0", po_data_vld); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] o;
    logic       v;
    for (int k = 0; k < 256; k++) hist[k] = 64'($urandom_range(0, 2000));
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      pi_histo_vld = 1'b1; pi_histo_data = hist[i];
    end
    @(posedge clk); #1;
    rst = 1'b1; pi_histo_vld = 1'b0; pi_histo_data = 64'd0;
    pi_data_vld = 1'b1; pi_data = 8'hAA;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (po_data !== 8'd0)      begin n_bad++; $display("FAIL rmid_po_data: got %0d expected 0", po_data); end
    n_cmp++; if (po_data_vld !== 1'b0)  begin n_bad++; $display("FAIL rmid_po_data_vld: got %b expected 0", po_data_vld); end
    n_cmp++; if (po_lut_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_lut_ready: got %b expected 0", po_lut_ready); end
    n_cmp++; if (po_frame_err !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_err: got %b expected 0", po_frame_err); end
    rst = 1'b0; pi_data_vld = 1'b0;
    model_ready = 1'b0;
    get_pix(8'd37, o, v);
    n_cmp++; if (o !== 8'd37) begin n_bad++; $display("FAIL rmid_identity: got %0d expected 37", o); end
    build_model();
    send_burst(256);
    repeat (6) @(posedge clk);
    do_vsync();
    commit_model();
    n_cmp++; if (po_lut_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_recommit_ready: got %b expected 1", po_lut_ready); end
    for (int p = 0; p < 256; p++) begin
      get_pix(8'(p), o, v);
      n_cmp++; if (o !== exp_map(8'(p))) begin n_bad++; $display("FAIL rmid_lut: pixel %0d got %0d expected %0d", p, o, exp_map(8'(p))); end
    end
  endtask

  initial begin
    model_ready = 1'b0;
    test_reset();
    test_truncated();
    test_uniform();
    test_ping_pong();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
